// File: rtl/divider_control.sv
// Sequencer for a 32-bit restoring shift/subtract divider: INIT, 32 DIV iterations, FIX, DONE.
// Optional DIV_ZERO_DET_EN adds Divisor_zero/Div_zero and skips straight to DONE on a zero divisor.
module divider_control (
  input  logic clk,
  input  logic Reset,
  input  logic Run,
  input  logic ALU_carry,
`ifdef DIV_ZERO_DET_EN
  input  logic Divisor_zero,
  output logic Div_zero,
`endif
  output logic Init_ctrl,
  output logic W_ctrl,
  output logic SLL_ctrl,
  output logic SRL_ctrl,
  output logic ALU_ctrl,
  output logic Ready,
  output logic Busy
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       start;

  // Run is only honoured when no division is in flight.
  assign start = Run && ((state_q == StIdle) || (state_q == StDone));

`ifdef DIV_ZERO_DET_EN
  logic div_zero_q, div_zero_d;

  always_comb begin
    div_zero_d = div_zero_q;
    if (start) begin
      div_zero_d = Divisor_zero;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
    end
  end

  assign Div_zero = div_zero_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = 5'd0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
`ifdef DIV_ZERO_DET_EN
          state_d = Divisor_zero ? StDone : StInit;
`else
          state_d = StInit;
`endif
        end
      end
      StInit: begin
        state_d = StDiv;
      end
      StDiv: begin
        if (cnt_q == 5'd31) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StFix: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode; W_ctrl in DIV is the only input-dependent output.
  always_comb begin
    Init_ctrl = 1'b0;
    W_ctrl    = 1'b0;
    SLL_ctrl  = 1'b0;
    SRL_ctrl  = 1'b0;
    ALU_ctrl  = 1'b0;
    Ready     = 1'b0;
    Busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StInit: begin
        Init_ctrl = 1'b1;
        W_ctrl    = 1'b1;
        SLL_ctrl  = 1'b1;
        Busy      = 1'b1;
      end
      StDiv: begin
        ALU_ctrl = 1'b1;
        SLL_ctrl = 1'b1;
        Busy     = 1'b1;
        W_ctrl   = ~ALU_carry;
      end
      StFix: begin
        SRL_ctrl = 1'b1;
        Busy     = 1'b1;
      end
      StDone: begin
        Ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
